uart_rx_core: RTL and testbench

//   Serial UART receiver feeding the Wishbone UART register slave. Synchronises the rx pin
//   and detects start bits. Samples each bit at mid-bit and assembles LSB-first frames.

---
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx_core.sv | 144 ++++++++++++++
 tb/tb_uart_rx_core.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: bundle between the UART receive core and its register-side user.
//   rx             serial line into the receiver (idle high)
//   rx_read        1-cycle pulse: the register slave consumed dout
//   dout           last good received byte
//   rx_buffer_full dout holds unread data
//   frame_err      sticky: stop bit sampled low
//   overrun        sticky: a new byte landed while the buffer was still full
//   rx_busy        a frame is being received
// Modports: master = line/register side driving rx and rx_read; slave = receiver core.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx;
  logic                 rx_read;
  logic [DATA_BITS-1:0] dout;
  logic                 rx_buffer_full;
  logic                 frame_err;
  logic                 overrun;
  logic                 rx_busy;

  modport master (
    output rx, rx_read,
    input  dout, rx_buffer_full, frame_err, overrun, rx_busy
  );

  modport slave (
    input  rx, rx_read,
    output dout, rx_buffer_full, frame_err, overrun, rx_busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: serial UART receiver, no parity, one stop bit, LSB first.
// Synchronises rx through two flops, qualifies the start bit at mid-bit, samples each
// data bit and the stop bit one bit period apart, and keeps a one-byte buffer.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  uart_rx_if.slave (rx, rx_read in; dout, rx_buffer_full, frame_err,
//        overrun, rx_busy out)
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 full_q, full_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic                 bit_tick;
  logic                 load;
  logic                 ferr_set;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    dout_d    = dout_q;
    full_d    = full_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    load      = 1'b0;
    ferr_set  = 1'b0;
    bit_tick  = (clk_cnt_q == FULL_M1);

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        bit_cnt_d = '0;
        // A line that is high again at mid start bit was only a glitch.
        if (clk_cnt_q == HALF_M1) state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_tick) begin
          shreg_d   = {rx_s_q, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          if (rx_s_q) begin
            dout_d  = shreg_q;
            load    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Stay here while the line is held low so a break never looks like a start.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Read clears first; a same-cycle load or frame error then takes precedence.
    if (bus.rx_read) begin
      full_d = 1'b0;
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (load) begin
      full_d = 1'b1;
      if (full_q && !bus.rx_read) ovr_d = 1'b1;
    end
    if (ferr_set) ferr_d = 1'b1;

    if ((state_d != state_q) || bit_tick || (state_q == S_IDLE) || (state_q == S_BREAK))
      clk_cnt_d = '0;
    else
      clk_cnt_d = clk_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      full_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      full_q    <= full_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.dout           = dout_q;
  assign bus.rx_buffer_full = full_q;
  assign bus.frame_err      = ferr_q;
  assign bus.overrun        = ovr_q;
  assign bus.rx_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed bench for uart_rx_core with CLKS_PER_BIT=16, DATA_BITS=8.
// Inputs change on the falling clock edge; outputs are read on the falling edge or
// #1 after a rising edge.
module tb_uart_rx_core;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx_core #(
    .CLKS_PER_BIT(16),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned frame_t0 = 0;
  int unsigned load_cyc = 0;
  logic        prev_full = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Records the rising-edge count at which rx_buffer_full goes 0 -> 1.
  always @(posedge clk) begin
    #1;
    if (bus.rx_buffer_full && !prev_full) load_cyc = cyc;
    prev_full = bus.rx_buffer_full;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame. The start bit goes low on a falling edge; the next rising edge
  // (the first to capture it) is edge 0, and the byte should load on edge 154.
  // With good_stop=0 the task returns at the start of the stop bit with rx still low.
  // read_on_load pulses rx_read during the cycle ending at edge 154.
  task automatic send_frame(input logic [7:0] b, input bit good_stop, input bit read_on_load);
    @(negedge clk);
    frame_t0 = cyc;
    bus.rx = 1'b0;
    repeat (15) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.rx = b[i];
      repeat (15) @(negedge clk);
    end
    if (good_stop) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        bus.rx      = 1'b1;
        bus.rx_read = read_on_load && (c == 10);
      end
    end else begin
      @(negedge clk);
      bus.rx = 1'b0;
    end
  endtask

  task automatic pulse_read();
    @(negedge clk);
    bus.rx_read = 1'b1;
    @(negedge clk);
    bus.rx_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.rx      = 1'b1;
    bus.rx_read = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(bus.dout), 32'h00);
    check("rst_full", 32'(bus.rx_buffer_full), 32'h0);
    check("rst_ferr", 32'(bus.frame_err), 32'h0);
    check("rst_ovr", 32'(bus.overrun), 32'h0);
    check("rst_busy", 32'(bus.rx_busy), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5, good stop bit: load on edge 154, i.e. 155 rising edges after the drive point
    load_cyc = 0;
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_latency", load_cyc - frame_t0, 32'd155);
    check("a5_dout", 32'(bus.dout), 32'hA5);
    check("a5_full", 32'(bus.rx_buffer_full), 32'h1);
    check("a5_ferr", 32'(bus.frame_err), 32'h0);
    check("a5_ovr", 32'(bus.overrun), 32'h0);
    pulse_read();
    check("a5_read_full", 32'(bus.rx_buffer_full), 32'h0);
    check("a5_read_dout", 32'(bus.dout), 32'hA5);

    // 4-cycle low glitch on an idle line
    repeat (4) @(negedge clk);
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_mid", 32'(bus.rx_busy), 32'h1);
    bus.rx = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_busy_end", 32'(bus.rx_busy), 32'h0);
    check("glitch_full", 32'(bus.rx_buffer_full), 32'h0);
    check("glitch_ferr", 32'(bus.frame_err), 32'h0);

    // 0x3C with the stop bit held low for 40 cycles
    repeat (4) @(negedge clk);
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (24) @(negedge clk);
    check("brk_ferr", 32'(bus.frame_err), 32'h1);
    check("brk_dout", 32'(bus.dout), 32'hA5);
    check("brk_full", 32'(bus.rx_buffer_full), 32'h0);
    repeat (15) @(negedge clk);
    check("brk_busy_low", 32'(bus.rx_busy), 32'h1);
    @(negedge clk);
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_idle", 32'(bus.rx_busy), 32'h0);
    repeat (200) @(negedge clk);
    check("brk_no_frame", 32'(bus.rx_buffer_full), 32'h0);
    pulse_read();
    check("brk_read_ferr", 32'(bus.frame_err), 32'h0);

    // 0x11 then 0x22, no read in between
    send_frame(8'h11, 1'b1, 1'b0);
    check("ovr_first_dout", 32'(bus.dout), 32'h11);
    check("ovr_first_ovr", 32'(bus.overrun), 32'h0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ovr_dout", 32'(bus.dout), 32'h22);
    check("ovr_flag", 32'(bus.overrun), 32'h1);
    check("ovr_full", 32'(bus.rx_buffer_full), 32'h1);
    pulse_read();
    check("ovr_read_full", 32'(bus.rx_buffer_full), 32'h0);
    check("ovr_read_ovr", 32'(bus.overrun), 32'h0);
    check("ovr_read_dout", 32'(bus.dout), 32'h22);

    // Buffer full with 0x5A, then 0x55 arrives with rx_read on the load cycle
    send_frame(8'h5A, 1'b1, 1'b0);
    check("ld_pre_full", 32'(bus.rx_buffer_full), 32'h1);
    send_frame(8'h55, 1'b1, 1'b1);
    check("ld_full", 32'(bus.rx_buffer_full), 32'h1);
    check("ld_ovr", 32'(bus.overrun), 32'h0);
    check("ld_dout", 32'(bus.dout), 32'h55);

    // Reset during bit 4 of 0xF0 (line high there), released before the frame ends
    fork
      send_frame(8'hF0, 1'b1, 1'b0);
      begin
        repeat (85) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_dout", 32'(bus.dout), 32'h00);
        check("mid_rst_full", 32'(bus.rx_buffer_full), 32'h0);
        check("mid_rst_ferr", 32'(bus.frame_err), 32'h0);
        check("mid_rst_ovr", 32'(bus.overrun), 32'h0);
        check("mid_rst_busy", 32'(bus.rx_busy), 32'h0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
      end
    join
    check("post_rst_empty", 32'(bus.rx_buffer_full), 32'h0);

    load_cyc = 0;
    send_frame(8'h0F, 1'b1, 1'b0);
    check("fresh_latency", load_cyc - frame_t0, 32'd155);
    check("fresh_dout", 32'(bus.dout), 32'h0F);
    check("fresh_full", 32'(bus.rx_buffer_full), 32'h1);
    check("fresh_ferr", 32'(bus.frame_err), 32'h0);
    check("fresh_ovr", 32'(bus.overrun), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
